// File: rtl/in_spike_collector.sv
// Double-buffered axon spike collector: packets land in a shadow vector, which is published on each tick.
// Optional distinct-spike counter is built when IN_SPIKE_COUNT_EN is defined.
module in_spike_collector #(
    parameter int NUM_AXONS          = 256,
    parameter int AXON_CNT_BIT_WIDTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            tick_i,
    input  logic                            pkt_valid_i,
    input  logic [AXON_CNT_BIT_WIDTH-1:0]   pkt_axon_i,
    output logic                            pkt_ready_o,
    output logic [NUM_AXONS-1:0]            spike_o,
    output logic                            start_o,
    output logic [AXON_CNT_BIT_WIDTH:0]     spike_cnt_o,
    output logic [1:0]                      err_o
);
    // state     | meaning
    // S_COLLECT | gathering packets for the current step, waiting for tick
    // S_START   | publish just happened, start pulse to downstream
    typedef enum logic {S_COLLECT = 1'b0, S_START = 1'b1} stateE;

    localparam int CW = AXON_CNT_BIT_WIDTH + 1;

    stateE                 state, stateNext;
    logic                  startFlag;
    logic                  readyQ;
    logic [1:0]            errQ;
    logic [NUM_AXONS-1:0]  shadow, shadowNext, spikeQ, axonHot;
    logic                  accept, inRange, hit, publish, overrun;

    assign accept  = pkt_valid_i & readyQ;
    assign inRange = {1'b0, pkt_axon_i} < CW'(NUM_AXONS);
    assign axonHot = NUM_AXONS'(1) << pkt_axon_i;
    assign hit     = accept & inRange;
    assign publish = (state == S_COLLECT) & tick_i;
    assign overrun = (state == S_START) & tick_i;

    always_comb begin
        stateNext = state;
        startFlag = 1'b0;
        case (state)
            S_COLLECT: if (tick_i) stateNext = S_START;
            S_START: begin
                startFlag = 1'b1;
                stateNext = S_COLLECT;
            end
        endcase
    end

    // A packet arriving in the tick cycle belongs to the new step.
    always_comb begin
        shadowNext = publish ? '0 : shadow;
        if (hit) shadowNext = shadowNext | axonHot;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= S_COLLECT;
            readyQ <= 1'b0;
            errQ   <= 2'b00;
            shadow <= '0;
            spikeQ <= '0;
        end else begin
            state  <= stateNext;
            readyQ <= 1'b1;
            errQ   <= errQ | {overrun, accept & ~inRange};
            shadow <= shadowNext;
            if (publish) spikeQ <= shadow;
        end
    end

`ifdef IN_SPIKE_COUNT_EN
    logic [CW-1:0] cnt, cntQ;
    logic          isNew;

    assign isNew = hit & ~|(shadow & axonHot);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt  <= '0;
            cntQ <= '0;
        end else if (publish) begin
            cntQ <= cnt;
            cnt  <= hit ? CW'(1) : '0;
        end else if (isNew) begin
            cnt  <= cnt + CW'(1);
        end
    end

    assign spike_cnt_o = cntQ;
`else
    assign spike_cnt_o = '0;
`endif

    assign pkt_ready_o = readyQ;
    assign spike_o     = spikeQ;
    assign start_o     = startFlag;
    assign err_o       = errQ;
endmodule

// File: tb/tb_in_spike_collector.sv
// Directed bench for in_spike_collector: table of collect/publish steps plus hand-written corner sequences.
module tb_in_spike_collector;
    logic         clk_i = 1'b0;
    logic         rst_n_i, tick_i, pkt_valid_i;
    logic [7:0]   pkt_axon_i;
    logic         pkt_ready_o, start_o;
    logic [255:0] spike_o;
    logic [8:0]   spike_cnt_o;
    logic [1:0]   err_o;
    logic         readyB, startB;
    logic [199:0] spikeB;
    logic [8:0]   cntB;
    logic [1:0]   errB;

    int tests = 0;
    int failed = 0;

    always #5 clk_i = ~clk_i;

    in_spike_collector #(.NUM_AXONS(256), .AXON_CNT_BIT_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .tick_i(tick_i), .pkt_valid_i(pkt_valid_i),
        .pkt_axon_i(pkt_axon_i), .pkt_ready_o(pkt_ready_o), .spike_o(spike_o),
        .start_o(start_o), .spike_cnt_o(spike_cnt_o), .err_o(err_o));

    in_spike_collector #(.NUM_AXONS(200), .AXON_CNT_BIT_WIDTH(8)) dut200 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .tick_i(tick_i), .pkt_valid_i(pkt_valid_i),
        .pkt_axon_i(pkt_axon_i), .pkt_ready_o(readyB), .spike_o(spikeB),
        .start_o(startB), .spike_cnt_o(cntB), .err_o(errB));

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][7:0] axon;
        logic [8:0]      expCnt;
    } vecT;

    vecT vecs [4];

    function automatic logic [8:0] expC(input int n);
`ifdef IN_SPIKE_COUNT_EN
        return 9'(n);
`else
        return 9'(n - n);
`endif
    endfunction

    function automatic logic [255:0] bitOf(input int a);
        logic [255:0] one;
        one = 256'(1);
        return one << a;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sendPkt(input int a);
        pkt_valid_i = 1'b1;
        pkt_axon_i  = 8'(a);
        step();
        pkt_valid_i = 1'b0;
    endtask

    task automatic doTick();
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
    endtask

    initial begin
        logic [255:0] expVec;

        vecs[0] = '{n: 3'd3, axon: {8'd0, 8'd255, 8'd17, 8'd3}, expCnt: expC(3)};
        vecs[1] = '{n: 3'd4, axon: {8'd6, 8'd5, 8'd5, 8'd5}, expCnt: expC(2)};
        vecs[2] = '{n: 3'd2, axon: {8'd0, 8'd0, 8'd128, 8'd0}, expCnt: expC(2)};
        vecs[3] = '{n: 3'd0, axon: '0, expCnt: expC(0)};

        rst_n_i = 1'b0; tick_i = 1'b0; pkt_valid_i = 1'b0; pkt_axon_i = '0;
        step(); step();
        chk("rst_ready", 256'(pkt_ready_o), 256'(0));
        chk("rst_spike", spike_o, '0);
        chk("rst_start", 256'(start_o), 256'(0));
        chk("rst_cnt", 256'(spike_cnt_o), 256'(0));
        chk("rst_err", 256'(err_o), 256'(0));
        rst_n_i = 1'b1;
        step();
        chk("ready_after_rst", 256'(pkt_ready_o), 256'(1));

        for (int i = 0; i < 4; i++) begin
            expVec = '0;
            for (int j = 0; j < int'(vecs[i].n); j++) begin
                sendPkt(int'(vecs[i].axon[j]));
                expVec |= bitOf(int'(vecs[i].axon[j]));
            end
            doTick();
            chk($sformatf("vec%0d_start", i), 256'(start_o), 256'(1));
            chk($sformatf("vec%0d_spike", i), spike_o, expVec);
            chk($sformatf("vec%0d_cnt", i), 256'(spike_cnt_o), 256'(vecs[i].expCnt));
            step();
            chk($sformatf("vec%0d_start_end", i), 256'(start_o), 256'(0));
        end

        // packet in the tick cycle goes to the next step
        sendPkt(2);
        pkt_valid_i = 1'b1; pkt_axon_i = 8'd9; tick_i = 1'b1;
        step();
        pkt_valid_i = 1'b0; tick_i = 1'b0;
        chk("tickpkt_spike1", spike_o, bitOf(2));
        chk("tickpkt_cnt1", 256'(spike_cnt_o), 256'(expC(1)));
        step();
        doTick();
        chk("tickpkt_spike2", spike_o, bitOf(9));
        chk("tickpkt_cnt2", 256'(spike_cnt_o), 256'(expC(1)));
        chk("tickpkt_start2", 256'(start_o), 256'(1));
        step();

        // back-to-back ticks: first publishes, second flagged
        sendPkt(7);
        tick_i = 1'b1;
        step();
        chk("b2b_start1", 256'(start_o), 256'(1));
        chk("b2b_spike1", spike_o, bitOf(7));
        step();
        tick_i = 1'b0;
        chk("b2b_nostart", 256'(start_o), 256'(0));
        chk("b2b_err", 256'(err_o), 256'(2));
        chk("b2b_spike_hold", spike_o, bitOf(7));
        step();
        chk("b2b_nostart2", 256'(start_o), 256'(0));

        // out-of-range axon on a 200-axon instance
        rst_n_i = 1'b0; step(); rst_n_i = 1'b1; step();
        chk("err_cleared", 256'(err_o), 256'(0));
        sendPkt(210);
        chk("oor_err200", 256'(errB), 256'(1));
        chk("oor_err256", 256'(err_o), 256'(0));
        doTick();
        chk("oor_spike200", 256'(spikeB), '0);
        chk("oor_cnt200", 256'(cntB), 256'(0));
        chk("oor_start200", 256'(startB), 256'(1));
        chk("oor_spike256", spike_o, bitOf(210));
        chk("oor_cnt256", 256'(spike_cnt_o), 256'(expC(1)));
        step();

        // reset mid-step discards collected spikes
        sendPkt(1);
        sendPkt(2);
        rst_n_i = 1'b0;
        #2;
        chk("async_clr_spike", spike_o, '0);
        chk("async_ready", 256'(pkt_ready_o), 256'(0));
        step();
        rst_n_i = 1'b1;
        step(); step();
        chk("rstmid_nostart", 256'(start_o), 256'(0));
        doTick();
        chk("rstmid_spike", spike_o, '0);
        chk("rstmid_cnt", 256'(spike_cnt_o), 256'(0));
        chk("rstmid_err", 256'(err_o), 256'(0));
        chk("rstmid_start", 256'(start_o), 256'(1));
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/in_spike_collector.md
# in_spike_collector

Upstream stage of the per-core input spike buffer. Collects axon-addressed spike packets arriving from the NoC router interface during a time step into a shadow vector. On each time-step tick it publishes the vector as a stable `NUM_AXONS`-wide spike word plus a one-cycle start pulse; these drive the buffer's `spike_in` and `start_i`. Double-buffered, so collection of step N+1 overlaps consumption of step N.

## Interface
Parameters:
- `NUM_AXONS`, 256: axons per core; width of published vector.
- `AXON_CNT_BIT_WIDTH`, 8: width of axon address; `2^AXON_CNT_BIT_WIDTH >= NUM_AXONS`.

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `tick_i`  in  1  time-step boundary, single-cycle pulse.
- `pkt_valid_i`  in  1  incoming spike packet valid.
- `pkt_axon_i`  in  `AXON_CNT_BIT_WIDTH`  target axon index.
- `pkt_ready_o`  out  1  packet accepted when `pkt_valid_i & pkt_ready_o`.
- `spike_o`  out  `NUM_AXONS`  published spike vector, stable between publishes.
- `start_o`  out  1  one-cycle pulse, cycle after publish.
- `spike_cnt_o`  out  `AXON_CNT_BIT_WIDTH+1`  distinct axons spiking in published step.
- `err_o`  out  2  sticky: bit0 out-of-range axon, bit1 tick overrun.

## Operation
- Registers: `shadow[NUM_AXONS]`, `cnt` (distinct-bit counter), FSM {`S_COLLECT`, `S_START`}.
- Reset: `spike_o`=0, `shadow`=0, `cnt`=0, `start_o`=0, `spike_cnt_o`=0, `err_o`=0, `pkt_ready_o`=0 while reset held, FSM=`S_COLLECT`.
- `pkt_ready_o`=1 in both states once out of reset; no backpressure.
- Accept with `pkt_axon_i < NUM_AXONS`: `shadow[pkt_axon_i]`<=1; `cnt` increments only if bit was 0 (duplicates idempotent, not counted).
- Accept with `pkt_axon_i >= NUM_AXONS`: packet dropped, `shadow`/`cnt` unchanged, `err_o[0]`<=1.
- `S_COLLECT` + `tick_i`: `spike_o`<=`shadow`, `spike_cnt_o`<=`cnt`; `shadow`/`cnt` cleared, except that a packet accepted in the tick cycle lands in the new `shadow` (`cnt`=1) and is excluded from the published vector; -> `S_START`.
- `S_START`: `start_o`=1 for exactly this cycle; packets accepted normally into new step; -> `S_COLLECT`.
- `S_START` + `tick_i`: tick ignored (no publish), `err_o[1]`<=1.
- `err_o` bits clear only on reset.

## Timing
- Packet accepted in cycle t: `shadow` bit visible at t+1.
- Tick in cycle T: `spike_o`/`spike_cnt_o` update at end of T; `start_o` high in T+1 only; downstream may sample `spike_o` on `start_o` rising edge.
- Minimum tick spacing 2 cycles; back-to-back ticks -> second flagged, first publishes normally.
- `spike_o` holds value until next accepted tick.
- Reset asserted mid-step or during `S_START`: all state cleared immediately; collected spikes lost; no `start_o` pulse.
- Counter width `AXON_CNT_BIT_WIDTH+1` holds `NUM_AXONS` without wrap.

## Configuration
- `IN_SPIKE_COUNT_EN` defined: `cnt` logic built, `spike_cnt_o` reports distinct spike count as above.
- Undefined: no counter logic; `spike_cnt_o` tied to 0; all other behaviour identical.

## Test plan
- Reset, then packets to axons 3, 17, 255; tick at cycle 10 -> cycle 11 `start_o`=1 one cycle, `spike_o` bits 3/17/255 set only, `spike_cnt_o`=3.
- Axon 5 sent three times, axon 6 once; tick -> bits 5, 6 set, `spike_cnt_o`=2.
- Packet to axon 9 in tick cycle, axon 2 earlier -> published vector bit 2 only; next tick publishes bit 9 only, `spike_cnt_o`=1.
- `NUM_AXONS`=200: packet axon 210 -> dropped, `err_o`=01, next publish all-zero, `spike_cnt_o`=0.
- Ticks in cycles 20 and 21 -> one publish, one `start_o` pulse at 21, `err_o[1]`=1.
- Packets to axons 1, 2; reset pulse before tick; then tick -> `spike_o`=0, `spike_cnt_o`=0, `err_o`=00.
